// File: rtl/fll_if.sv
// rtl/fll_if.sv - control/status bundle between an FLL supervisor and fll_ctrl
interface fll_if #(
  parameter int NW   = 8,
  parameter int CNTW = 8,
  parameter int CW   = 12
);
  logic            en_i;
  logic            hold_i;
  logic [NW-1:0]   num_i;
  logic [CNTW-1:0] tgt_i;
  logic            fbk_i;
  logic [CW-1:0]   ctl_o;
  logic [CNTW:0]   err_o;
  logic            upd_o;
  logic            lock_o;
  logic            sat_o;
  logic [1:0]      sts_o;

  modport master (
    output en_i, hold_i, num_i, tgt_i, fbk_i,
    input  ctl_o, err_o, upd_o, lock_o, sat_o, sts_o
  );

  modport slave (
    input  en_i, hold_i, num_i, tgt_i, fbk_i,
    output ctl_o, err_o, upd_o, lock_o, sat_o, sts_o
  );
endinterface

// File: rtl/fll_ctrl.sv
// rtl/fll_ctrl.sv - windowed frequency-locked-loop controller with adaptive gain and lock detect
module fll_ctrl #(
  parameter int NW       = 8,
  parameter int CNTW     = 8,
  parameter int CW       = 12,
  parameter int CTL_INIT = 2048,
  parameter int GS_MAX   = 6,
  parameter int GS_MIN   = 0,
  parameter int LOCK_TOL = 1,
  parameter int LOCK_N   = 4
) (
  input logic clk_i,
  input logic rst_i,
  fll_if.slave bus
);

  localparam int EW  = CNTW + 1;
  localparam int SHW = (GS_MAX > 0) ? $clog2(GS_MAX + 1) : 1;
  localparam int RW  = (LOCK_N > 0) ? $clog2(LOCK_N + 1) : 1;
  // Wide enough for ctl plus the largest shifted error, with a sign bit and an overflow bit.
  localparam int SW  = ((CW > EW + GS_MAX) ? CW : EW + GS_MAX) + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [NW-1:0]   wcnt, wcnt_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic [RW-1:0]   run, run_nx;
  logic [SHW-1:0]  sh, sh_nx;
  logic            prev_v, prev_v_nx;
  logic            prev_neg, prev_neg_nx;
  logic [CW-1:0]   ctl, ctl_nx;
  logic [EW-1:0]   err, err_nx;
  logic            upd, upd_nx;
  logic            lock, lock_nx;
  logic            sat, sat_nx;

  logic            wnd_end;
  logic [CNTW:0]   cnt_inc;
  logic [CNTW-1:0] meas;
  logic [EW-1:0]   err_w;
  logic [EW-1:0]   err_abs;
  logic            in_tol;
  logic [SW-1:0]   step;
  logic [SW-1:0]   sum_w;
  logic [CW-1:0]   clip_v;
  logic            clip_s;
  logic [RW-1:0]   run_inc;

  // Window measurement, error, gain-scaled step and clipped control word candidate.
  always_comb begin
    wnd_end = (wcnt >= bus.num_i);
    cnt_inc = {1'b0, cnt} + {{CNTW{1'b0}}, bus.fbk_i};
    meas    = cnt_inc[CNTW] ? {CNTW{1'b1}} : cnt_inc[CNTW-1:0];
    err_w   = {1'b0, bus.tgt_i} - {1'b0, meas};
    err_abs = err_w[EW-1] ? (~err_w + EW'(1)) : err_w;
    in_tol  = (int'(err_abs) <= LOCK_TOL);
    step    = $signed({{(SW-EW){err_w[EW-1]}}, err_w}) <<< sh;
    sum_w   = {{(SW-CW){1'b0}}, ctl} + step;
    clip_v  = sum_w[CW-1:0];
    clip_s  = 1'b0;
    if (sum_w[SW-1]) begin
      clip_v = '0;
      clip_s = 1'b1;
    end else if (|sum_w[SW-2:CW]) begin
      clip_v = '1;
      clip_s = 1'b1;
    end
    run_inc = (run == RW'(LOCK_N)) ? run : run + RW'(1);
  end

  // Next-state logic: window bookkeeping, loop update, gain adaptation, lock and mode changes.
  always_comb begin
    state_nx    = state;
    wcnt_nx     = wcnt;
    cnt_nx      = cnt;
    run_nx      = run;
    sh_nx       = sh;
    prev_v_nx   = prev_v;
    prev_neg_nx = prev_neg;
    ctl_nx      = ctl;
    err_nx      = err;
    upd_nx      = 1'b0;
    lock_nx     = lock;
    sat_nx      = sat;

    if (!bus.en_i) begin
      state_nx  = S_IDLE;
      wcnt_nx   = '0;
      cnt_nx    = '0;
      run_nx    = '0;
      lock_nx   = 1'b0;
      sh_nx     = SHW'(GS_MAX);
      prev_v_nx = 1'b0;
    end else if (state == S_IDLE) begin
      state_nx = S_ACQ;
    end else begin
      if (wnd_end) begin
        wcnt_nx = '0;
        cnt_nx  = '0;
        err_nx  = err_w;
        upd_nx  = 1'b1;
        if (state == S_HOLD) begin
          sat_nx = 1'b0;
        end else begin
          ctl_nx = clip_v;
          sat_nx = clip_s;
        end
        if (in_tol) begin
          run_nx = run_inc;
          if (run_inc == RW'(LOCK_N)) lock_nx = 1'b1;
        end else begin
          run_nx  = '0;
          lock_nx = 1'b0;
        end
        if (state == S_ACQ) begin
          // Halve the gain each time the error changes sign; zero error is ignored.
          if (err_w != '0) begin
            if (prev_v && (err_w[EW-1] != prev_neg))
              sh_nx = (sh > SHW'(GS_MIN)) ? sh - SHW'(1) : SHW'(GS_MIN);
            prev_v_nx   = 1'b1;
            prev_neg_nx = err_w[EW-1];
          end
          if (lock_nx) begin
            state_nx = S_TRACK;
            sh_nx    = SHW'(GS_MIN);
          end
        end else if (state == S_TRACK) begin
          if (!lock_nx) begin
            state_nx  = S_ACQ;
            sh_nx     = SHW'(GS_MAX);
            prev_v_nx = 1'b0;
          end
        end
      end else begin
        wcnt_nx = wcnt + NW'(1);
        cnt_nx  = meas;
      end

      // Hold entry/exit acts on any cycle; an end-cycle update above is still kept.
      if (state == S_HOLD) begin
        if (!bus.hold_i) begin
          state_nx  = lock_nx ? S_TRACK : S_ACQ;
          sh_nx     = lock_nx ? SHW'(GS_MIN) : SHW'(GS_MAX);
          prev_v_nx = 1'b0;
        end
      end else if (bus.hold_i) begin
        state_nx = S_HOLD;
      end
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      cnt      <= '0;
      run      <= '0;
      sh       <= SHW'(GS_MAX);
      prev_v   <= 1'b0;
      prev_neg <= 1'b0;
      ctl      <= CW'(CTL_INIT);
      err      <= '0;
      upd      <= 1'b0;
      lock     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      state    <= state_nx;
      wcnt     <= wcnt_nx;
      cnt      <= cnt_nx;
      run      <= run_nx;
      sh       <= sh_nx;
      prev_v   <= prev_v_nx;
      prev_neg <= prev_neg_nx;
      ctl      <= ctl_nx;
      err      <= err_nx;
      upd      <= upd_nx;
      lock     <= lock_nx;
      sat      <= sat_nx;
    end
  end

  assign bus.ctl_o  = ctl;
  assign bus.err_o  = err;
  assign bus.upd_o  = upd;
  assign bus.lock_o = lock;
  assign bus.sat_o  = sat;
  assign bus.sts_o  = state;

endmodule

// File: tb/tb_fll_ctrl.sv
// tb/tb_fll_ctrl.sv - directed self-checking bench for fll_ctrl
module tb_fll_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  int   fb_p;
  int   fb_k;
  int   ph;

  fll_if #(.NW(9), .CNTW(8), .CW(12)) bus ();

  fll_ctrl #(.NW(9), .CNTW(8), .CW(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feedback generator: fb_k pulses out of every fb_p cycles, so any window that is a
  // multiple of fb_p cycles sees exactly window*fb_k/fb_p pulses regardless of phase.
  always @(negedge clk) begin
    if (fb_p <= 0) begin
      ph = 0;
      bus.fbk_i = 1'b0;
    end else begin
      ph = (ph + 1 >= fb_p) ? 0 : ph + 1;
      bus.fbk_i = (ph < fb_k);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.en_i = 1'b0;
    bus.hold_i = 1'b0;
    bus.num_i = 9'd99;
    bus.tgt_i = 8'd50;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_upd(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (bus.upd_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: upd_o pulse not seen within 1000 cycles, required one", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fb_p = 0;
    fb_k = 0;
    bus.en_i = 1'b0;
    bus.hold_i = 1'b0;
    bus.num_i = 9'd99;
    bus.tgt_i = 8'd50;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ctl_o !== 12'd2048 || bus.err_o !== 9'd0 || bus.upd_o !== 1'b0 ||
        bus.lock_o !== 1'b0 || bus.sat_o !== 1'b0 || bus.sts_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_values: ctl=%0d err=%0d upd=%b lock=%b sat=%b sts=%0d, required 2048 0 0 0 0 0",
               bus.ctl_o, bus.err_o, bus.upd_o, bus.lock_o, bus.sat_o, bus.sts_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lock();
    fb_p = 2; fb_k = 1;
    do_reset();
    bus.en_i = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_upd("lock_upd");
      checks++;
      if (bus.err_o !== 9'd0 || bus.ctl_o !== 12'd2048) begin
        fails++;
        $display("FAIL lock_err_ctl w%0d: err=%0d ctl=%0d, required 0 2048", w, bus.err_o, bus.ctl_o);
      end
      checks++;
      if (bus.lock_o !== (w == 4)) begin
        fails++;
        $display("FAIL lock_flag w%0d: lock=%b, required %b", w, bus.lock_o, (w == 4));
      end
    end
    checks++;
    if (bus.sts_o !== 2'd2) begin
      fails++;
      $display("FAIL lock_state: sts=%0d, required 2", bus.sts_o);
    end
  endtask

  task automatic test_acq_gain();
    logic [11:0] exp_ctl [9];
    exp_ctl = '{12'd2688, 12'd2048, 12'd2368, 12'd2208, 12'd2288,
                12'd2248, 12'd2268, 12'd2258, 12'd2268};
    fb_p = 5; fb_k = 2;
    do_reset();
    bus.tgt_i = 8'd50;
    bus.en_i = 1'b1;
    for (int w = 0; w < 9; w++) begin
      wait_upd("gain_upd");
      checks++;
      if (bus.ctl_o !== exp_ctl[w] || bus.sat_o !== 1'b0) begin
        fails++;
        $display("FAIL gain_ctl w%0d: ctl=%0d sat=%b, required %0d 0", w, bus.ctl_o, bus.sat_o, exp_ctl[w]);
      end
      checks++;
      if (bus.err_o !== ((w % 2 == 0) ? 9'd10 : 9'h1F6)) begin
        fails++;
        $display("FAIL gain_err w%0d: err=%h, required %h", w, bus.err_o, (w % 2 == 0) ? 9'd10 : 9'h1F6);
      end
      bus.tgt_i = (w % 2 == 0) ? 8'd30 : 8'd50;
    end
  endtask

  task automatic test_saturation();
    logic [11:0] exp_ctl [5];
    logic        exp_sat [5];
    exp_ctl = '{12'd3328, 12'd4095, 12'd1535, 12'd255, 12'd0};
    exp_sat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    fb_p = 5; fb_k = 2;
    do_reset();
    bus.tgt_i = 8'd60;
    bus.en_i = 1'b1;
    for (int w = 0; w < 5; w++) begin
      wait_upd("sat_upd");
      checks++;
      if (bus.ctl_o !== exp_ctl[w] || bus.sat_o !== exp_sat[w]) begin
        fails++;
        $display("FAIL sat_ctl w%0d: ctl=%0d sat=%b, required %0d %b", w, bus.ctl_o, bus.sat_o, exp_ctl[w], exp_sat[w]);
      end
      if (w == 1) bus.tgt_i = 8'd0;
    end
  endtask

  task automatic test_hold();
    fb_p = 2; fb_k = 1;
    do_reset();
    bus.en_i = 1'b1;
    repeat (4) wait_upd("hold_lock_upd");
    checks++;
    if (bus.lock_o !== 1'b1 || bus.sts_o !== 2'd2) begin
      fails++;
      $display("FAIL hold_prelock: lock=%b sts=%0d, required 1 2", bus.lock_o, bus.sts_o);
    end
    bus.tgt_i = 8'd60;
    bus.hold_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sts_o !== 2'd3) begin
      fails++;
      $display("FAIL hold_enter: sts=%0d, required 3", bus.sts_o);
    end
    wait_upd("hold_upd");
    checks++;
    if (bus.err_o !== 9'd10 || bus.ctl_o !== 12'd2048 || bus.lock_o !== 1'b0 ||
        bus.sat_o !== 1'b0 || bus.sts_o !== 2'd3) begin
      fails++;
      $display("FAIL hold_frozen: err=%0d ctl=%0d lock=%b sat=%b sts=%0d, required 10 2048 0 0 3",
               bus.err_o, bus.ctl_o, bus.lock_o, bus.sat_o, bus.sts_o);
    end
    bus.hold_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sts_o !== 2'd1) begin
      fails++;
      $display("FAIL hold_release: sts=%0d, required 1", bus.sts_o);
    end
    wait_upd("hold_acq_upd");
    checks++;
    if (bus.ctl_o !== 12'd2688) begin
      fails++;
      $display("FAIL hold_regain: ctl=%0d, required 2688", bus.ctl_o);
    end
  endtask

  task automatic test_cnt_sat();
    fb_p = 1; fb_k = 1;
    do_reset();
    bus.num_i = 9'd299;
    bus.tgt_i = 8'd200;
    bus.en_i = 1'b1;
    wait_upd("cnt_sat_upd");
    checks++;
    if (bus.err_o !== 9'h1C9 || bus.ctl_o !== 12'd0 || bus.sat_o !== 1'b1) begin
      fails++;
      $display("FAIL cnt_sat: err=%h ctl=%0d sat=%b, required 1c9 0 1", bus.err_o, bus.ctl_o, bus.sat_o);
    end
    bus.tgt_i = 8'd255;
    repeat (50) @(negedge clk);
    bus.num_i = 9'd10;
    @(negedge clk);
    checks++;
    if (bus.upd_o !== 1'b1 || bus.err_o !== 9'd204 || bus.ctl_o !== 12'd4095 || bus.sat_o !== 1'b1) begin
      fails++;
      $display("FAIL num_shrink: upd=%b err=%0d ctl=%0d sat=%b, required 1 204 4095 1",
               bus.upd_o, bus.err_o, bus.ctl_o, bus.sat_o);
    end
  endtask

  task automatic test_idle_and_reset();
    fb_p = 5; fb_k = 2;
    do_reset();
    bus.en_i = 1'b1;
    wait_upd("idle_upd");
    checks++;
    if (bus.ctl_o !== 12'd2688) begin
      fails++;
      $display("FAIL idle_pre: ctl=%0d, required 2688", bus.ctl_o);
    end
    bus.en_i = 1'b0;
    bus.hold_i = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.sts_o !== 2'd0 || bus.ctl_o !== 12'd2688 || bus.lock_o !== 1'b0 || bus.upd_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: sts=%0d ctl=%0d lock=%b upd=%b, required 0 2688 0 0",
               bus.sts_o, bus.ctl_o, bus.lock_o, bus.upd_o);
    end
    bus.hold_i = 1'b0;
    bus.en_i = 1'b1;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ctl_o !== 12'd2048 || bus.err_o !== 9'd0 || bus.upd_o !== 1'b0 ||
        bus.lock_o !== 1'b0 || bus.sat_o !== 1'b0 || bus.sts_o !== 2'd0) begin
      fails++;
      $display("FAIL async_reset: ctl=%0d err=%0d upd=%b lock=%b sat=%b sts=%0d, required 2048 0 0 0 0 0",
               bus.ctl_o, bus.err_o, bus.upd_o, bus.lock_o, bus.sat_o, bus.sts_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails = 0;
    ph = 0;
    bus.fbk_i = 1'b0;
    test_reset();
    test_lock();
    test_acq_gain();
    test_saturation();
    test_hold();
    test_cnt_sat();
    test_idle_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
